// File: rtl/spgd_pkg.sv
// Shared SPGD datapath definitions: default operand width, requester bound
// and a round-robin pick helper reusable by any arbiter in the datapath.
package spgd_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_REQ_MAX    = 16;

  // Index of the first set bit of valid scanning upward from ptr and wrapping
  // at n (ptr < n <= NUM_REQ_MAX). Returns -1 when no bit below n is set.
  function automatic int rr_pick(input logic [NUM_REQ_MAX-1:0] valid,
                                 input int ptr, input int n);
    int idx;
    int pick;
    pick = -1;
    for (int k = 0; k < NUM_REQ_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && (pick < 0) && valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/gen_mult.sv
// Pure combinational two's-complement multiplier with an exact full-width product.
module gen_mult #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] p
);

  // Sign-extend both operands to the product width so the result is exact.
  assign p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of one shared signed multiplier.
// Handshake: an item moves across an interface on a rising edge where both
// its valid and ready are high; a producer holds its payload stable while
// valid is high and ready is low, and ready never depends on a registered
// copy of the same handshake. Requester side: req_valid/req_ready per index.
// Result side: rsp_valid/rsp_ready; the whole pipeline stalls when a result
// is presented and not taken.
module mult_arbiter
  import spgd_pkg::*;
#(
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int NUM_REQ     = 4,
  parameter  int PIPE_STAGES = 2,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_p,
  output logic                          busy
);

  // Product stages after the operand stage (stage 2 .. PIPE_STAGES).
  localparam int NP = PIPE_STAGES - 1;

  logic                          advance;
  logic [NUM_REQ_MAX-1:0]        valid_ext;
  int                            pick;
  logic                          accept;
  logic [ID_W-1:0]               grant_id;
  logic [ID_W-1:0]               ptr_next;
  logic [ID_W-1:0]               rr_ptr;
  logic [DATA_WIDTH-1:0]         sel_a;
  logic [DATA_WIDTH-1:0]         sel_b;

  logic                          s1_valid;
  logic [ID_W-1:0]               s1_id;
  logic signed [DATA_WIDTH-1:0]  s1_a;
  logic signed [DATA_WIDTH-1:0]  s1_b;
  logic signed [2*DATA_WIDTH-1:0] mult_p;

  logic [NP-1:0]                 pv;
  logic [ID_W-1:0]               pid [NP];
  logic [2*DATA_WIDTH-1:0]       pp  [NP];

  assign advance = ~rsp_valid | rsp_ready;

  // Grant selection, operand mux and next pointer value.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
    pick      = rr_pick(valid_ext, int'(rr_ptr), NUM_REQ);
    accept    = advance && (pick >= 0);
    grant_id  = (pick >= 0) ? ID_W'(pick) : '0;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    ptr_next  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    sel_a     = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
    sel_b     = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pointer moves past the winner only when a request is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= ptr_next;
    end
  end

  // Operand stage: capture the granted pair; valid is 0 on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_id    <= grant_id;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
    end
  end

  gen_mult #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .a(s1_a),
    .b(s1_b),
    .p(mult_p)
  );

  // Product stages: register the multiplier output, then delay as a unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < NP; k++) begin
        pid[k] <= '0;
        pp[k]  <= '0;
      end
    end else if (advance) begin
      pv[0]  <= s1_valid;
      pid[0] <= s1_id;
      pp[0]  <= mult_p;
      for (int k = 1; k < NP; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
        pp[k]  <= pp[k-1];
      end
    end
  end

  assign rsp_valid = pv[NP-1];
  assign rsp_id    = pid[NP-1];
  assign rsp_p     = pp[NP-1];
  assign busy      = s1_valid | (|pv);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed tables and sequences plus random traffic
// against a queue-based reference model.
module tb_mult_arbiter;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int PS  = 2;
  localparam int IDW = 2;
  localparam int W   = IDW + 2*DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a = '0;
  logic [NR*DW-1:0]  req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [2*DW-1:0]   rsp_p;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: arbitration pointer and in-order result queue.
  int            mptr = 0;
  logic [W-1:0]  exp_q[$];
  logic [NR-1:0] acc_mask = '0;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[8];

  mult_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .PIPE_STAGES(PS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_p(rsp_p),
    .busy(busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b));
    return r[31:0];
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // Scoreboard: checks grants every cycle and results as they are consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      int           g;
      logic [NR-1:0] m;
      logic [W-1:0] e;
      g = (!rsp_valid || rsp_ready) ? model_grant(req_valid, mptr) : -1;
      m = '0;
      if (g >= 0) m[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(m));
      acc_mask = req_ready;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e[W-1:2*DW]));
          check("rsp_p", 64'(rsp_p), 64'(e[2*DW-1:0]));
        end
      end
      if (g >= 0) begin
        exp_q.push_back({IDW'(g), model_mul(req_a[g*DW +: DW], req_b[g*DW +: DW])});
        mptr = (g + 1) % NR;
      end
    end
  end

  // Reset with checks of the reset state; returns #1 after a rising edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_p", 64'(rsp_p), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{id: 2, a: 16'd3,    b: 16'hFFFB, p: 32'hFFFFFFF1};
    vecs[1] = '{id: 0, a: 16'h8000, b: 16'h8000, p: 32'h40000000};
    vecs[2] = '{id: 1, a: 16'h8000, b: 16'h7FFF, p: 32'hC0008000};
    vecs[3] = '{id: 3, a: 16'd0,    b: 16'd1234, p: 32'h00000000};
    vecs[4] = '{id: 1, a: 16'h7FFF, b: 16'h7FFF, p: 32'h3FFF0001};
    vecs[5] = '{id: 0, a: 16'hFFFF, b: 16'hFFFF, p: 32'h00000001};
    vecs[6] = '{id: 3, a: 16'hFFFF, b: 16'd1,    p: 32'hFFFFFFFF};
    vecs[7] = '{id: 2, a: 16'd100,  b: 16'hFF9C, p: 32'hFFFFD8F0};

    #1;
    do_reset();

    // Sparse traffic: each lone requester wins on its first valid cycle.
    set_req(3, 16'd9, 16'd2);
    req_valid = 4'b1000;
    @(negedge clk);
    check("sparse_ready3", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    check("sparse_ptr_after3", 64'(dut.rr_ptr), 64'(0));
    set_req(1, 16'hFFF0, 16'd4);
    req_valid = 4'b0010;
    @(negedge clk);
    check("sparse_ready1", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    check("sparse_ptr_after1", 64'(dut.rr_ptr), 64'(2));
    req_valid = '0;
    drain("sparse_drain");

    // Table of single requests: latency, tag and exact signed product.
    foreach (vecs[v]) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      @(negedge clk);
      check("vec_ready", 64'(req_ready), 64'(1) << vecs[v].id);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("vec_early_valid", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("vec_rsp_valid", 64'(rsp_valid), 64'(1));
      check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].id));
      check("vec_rsp_p", 64'(rsp_p), 64'(vecs[v].p));
      @(posedge clk); #1;
    end
    drain("vec_drain");

    // Fairness: all four held valid for eight accepts.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 16'(i + 1), 16'(10 * i + 3));
    req_valid = 4'b1111;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c < 8) check("fair_grant", 64'(req_ready), 64'(1) << (c % 4));
      if (c >= 2 && c < 10) begin
        check("fair_rsp_valid", 64'(rsp_valid), 64'(1));
        check("fair_rsp_id", 64'(rsp_id), 64'((c - 2) % 4));
      end else begin
        check("fair_rsp_idle", 64'(rsp_valid), 64'(0));
      end
      @(posedge clk); #1;
      if (c == 7) req_valid = '0;
    end
    drain("fair_drain");

    // Backpressure with two results in flight.
    do_reset();
    set_req(0, 16'd7, 16'd6);
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 16'hFFFC, 16'd9);
    req_valid = 4'b0010;
    @(negedge clk);
    @(posedge clk); #1;
    set_req(2, 16'd11, 16'd11);
    set_req(3, 16'hFFFE, 16'd50);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_id", 64'(rsp_id), 64'(0));
      check("bp_rsp_p", 64'(rsp_p), 64'(42));
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_busy", 64'(busy), 64'(1));
      check("bp_rr_ptr", 64'(dut.rr_ptr), 64'(2));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready", 64'(req_ready), 64'(4'b0100));
    check("bp_rel_id0", 64'(rsp_id), 64'(0));
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_rel_id1", 64'(rsp_id), 64'(1));
    check("bp_rel_p1", 64'(rsp_p), 64'(32'hFFFFFFDC));
    @(posedge clk); #1;
    req_valid = '0;
    drain("bp_drain");

    // Reset with two entries in flight: nothing is replayed afterwards.
    do_reset();
    set_req(2, 16'd5, 16'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 16'hFFFD, 16'd11);
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    check("mid_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
    end
    req_valid = 4'b1111;
    @(negedge clk);
    check("mid_first_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    drain("mid_drain");

    // Random traffic against the reference model.
    do_reset();
    acc_mask = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || acc_mask[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1;
            set_req(i,
                    ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                    ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom));
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("rand_drain");
    check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and pipeline sequencer that shares one signed `gen_mult` multiplier between `NUM_REQ` requesters in the SPGD datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle and pushes it through a registered multiply pipeline. It returns the full-width signed product tagged with the requester index, and supports output backpressure.

## Interface
- `DATA_WIDTH`, 16, operand width in bits; products are `2*DATA_WIDTH`.
- `NUM_REQ`, 4, number of requesters (2..16).
- `PIPE_STAGES`, 2, cycles from accept to result (minimum 2).
- `ID_W`, `$clog2(NUM_REQ)`, derived local width of the requester tag.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester operand pair valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*DATA_WIDTH  flattened operand A; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`  in  NUM_REQ*DATA_WIDTH  flattened operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_p`.
- `rsp_p`  out  2*DATA_WIDTH  signed product.
- `busy`  out  1  high while any pipeline stage holds a valid entry.

## Operation
- Handshake: a request is accepted on a rising edge when `req_valid[i] & req_ready[i]`. A requester holds `req_a`/`req_b` stable while valid and not ready.
- Arbitration: `req_ready` is combinational from `req_valid`, the round-robin pointer `rr_ptr` and `advance`.
  - Grant goes to the first asserted `req_valid` scanning from index `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - `rr_ptr` updates to (granted index + 1) mod `NUM_REQ` only on an accepted request. It holds otherwise.
- Pipeline enable: `advance = ~rsp_valid | rsp_ready`. When `advance` is low, all stages hold and `req_ready` is all zero. The pipeline stalls as a whole; there is no bubble collapsing.
- Stage 1 registers the granted operands, the id, and a valid bit. A valid bit is written as 0 when no request is accepted.
- `gen_mult` is fed from the stage 1 operand registers. Its output is registered in stage 2, and further stages (if `PIPE_STAGES` > 2) delay product, id and valid.
- The last stage drives `rsp_valid`, `rsp_id` and `rsp_p` directly, with no extra output register.
- Arithmetic: both operands are two's-complement. The product is exact at `2*DATA_WIDTH` bits, with no rounding and no saturation. The multiplier behaves as a pure combinational signed multiply.
- `busy` is the OR of all stage valid bits.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All stage valid bits are 0 and `rr_ptr` = 0.
  - Outputs: `rsp_valid` = 0, `rsp_id` = 0, `rsp_p` = 0, `busy` = 0.
  - `req_ready` is combinational; it evaluates to the grant as soon as reset is released.
- Latency: an accept on edge t gives `rsp_valid` high in the cycle after edge t+PIPE_STAGES-1, i.e. PIPE_STAGES cycles after accept, provided there is no stall.
- Throughput: one accept per cycle while `rsp_ready` is held high.
- Stall: while `rsp_valid & ~rsp_ready`, `rsp_p`/`rsp_id` hold exactly, no new request is accepted, and `rr_ptr` is frozen.
- Simultaneous events:
  - Requests arriving while the last stage drains with `rsp_ready` high are accepted in the same cycle.
  - A requester may reassert valid the cycle after acceptance. It then competes normally and gets lower priority than any other pending requester.
- Reset mid-operation: in-flight entries are discarded with no response. A requester whose handshake completed is not replayed.

## Structure
- Shared package `spgd_pkg`: default `DATA_WIDTH`, the `NUM_REQ` upper bound, and a round-robin priority-encode function, reusable by other arbiters.
- One sub-module: the existing `gen_mult` (`DATA_WIDTH`), instantiated once between stage 1 and stage 2.
- Arbiter, pointer and pipeline registers stay in `mult_arbiter`.

## Test plan
- Single requester: requester 2 sends a=3, b=-5 with `rsp_ready`=1 -> 2 cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_p`=-15 (0xFFFFFFF1).
- Fairness: all 4 requesters hold valid for 8 cycles -> accept order 0,1,2,3,0,1,2,3; `rsp_id` sequence matches with no gaps.
- Backpressure: `rsp_ready`=0 for 5 cycles while 2 results are in flight -> `rsp_p`/`rsp_id` stable, `req_ready`=0, `rr_ptr` frozen. After release, the results drain in order.
- Signed extremes:
  - -32768 * -32768 -> 1073741824 (0x40000000).
  - -32768 * 32767 -> -1073709056.
  - 0 * x -> 0.
- Reset mid-operation: assert `rst_n`=0 with 2 entries in flight -> `rsp_valid`=0 and `busy`=0 immediately; no response appears after release; the next grant starts at requester 0.
- Sparse traffic: requester 3 only, then requester 1 only -> each granted on first valid cycle; `rr_ptr` = 0 after the 3 grant, then 2 after the 1 grant.
